// File: rtl/complex_axpy_sequencer_pkg.sv
// Shared types and sizing helpers for the complex AXPY sequencer.
// Chunk math keeps an exact multiple of NI as a full last chunk rather than an empty one.
package complex_axpy_sequencer_pkg;

    localparam int ELEM_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int calc_nchunk(input int noe, input int ni);
        return (noe + ni - 1) / ni;
    endfunction

    function automatic int calc_last_lanes(input int noe, input int ni);
        return noe - (calc_nchunk(noe, ni) - 1) * ni;
    endfunction

endpackage

// File: rtl/axpy_tag_pipe.sv
// Fixed-depth shift register of {valid, chunk index, last} tracking reads through RAM + datapath latency.
// pending_o reports tags that have not yet reached the output stage.
module axpy_tag_pipe #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             flush_i,
    input  logic             vld_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             last_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             pending_o
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            last_q[0] <= last_i;
            idx_q[0]  <= idx_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                idx_q[i]  <= idx_q[i-1];
            end
        end
    end

    // The output stage is excluded so the controller can finish on the cycle of the final write.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending_o = pending_o | vld_q[i];
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign idx_o  = idx_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];

endmodule

// File: rtl/complex_axpy_sequencer.sv
// Streams ceil(NOE/NI) operand chunks to the complex multiply-add datapath and issues masked,
// latency-aligned write-backs; done pulses on the cycle after the final write.
module complex_axpy_sequencer
    import complex_axpy_sequencer_pkg::*;
#(
    parameter int NOE           = 19,
    parameter int NI            = 8,
    parameter int ELEMENT_WIDTH = ELEM_W_DEF,
    parameter int ADDR_WIDTH    = 8,
    parameter int RD_LAT        = 1,
    parameter int PIPE_LAT      = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op_in,
    input  logic [ELEMENT_WIDTH-1:0] constant_in,
    input  logic [ADDR_WIDTH-1:0]    a_base,
    input  logic [ADDR_WIDTH-1:0]    b_base,
    input  logic [ADDR_WIDTH-1:0]    dst_base,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr_a,
    output logic [ADDR_WIDTH-1:0]    rd_addr_b,
    output logic [ELEMENT_WIDTH-1:0] dp_constant,
    output logic                     dp_op,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [NI-1:0]            wr_mask,
    output logic                     busy,
    output logic                     done,
    output logic                     start_err
);

    localparam int NCHUNK     = calc_nchunk(NOE, NI);
    localparam int LAST_LANES = calc_last_lanes(NOE, NI);
    localparam int DEPTH      = RD_LAT + PIPE_LAT;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NCHUNK - 1);
    localparam logic [NI-1:0]         FULL_MASK = {NI{1'b1}};
    // Lane 0 sits in the MSB, so a partial chunk keeps its top LAST_LANES bits.
    localparam logic [NI-1:0]         LAST_MASK = FULL_MASK << (NI - LAST_LANES);

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
    logic                      op_q;
    logic [ELEMENT_WIDTH-1:0]  const_q;
    logic [ADDR_WIDTH-1:0]     a_q, b_q, dst_q;

    logic                      accept;
    logic                      tag_vld, tag_last, tag_pending;
    logic [ADDR_WIDTH-1:0]     tag_idx;

    assign accept = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            const_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= op_in;
                const_q <= constant_in;
                a_q     <= a_base;
                b_q     <= b_base;
                dst_q   <= dst_base;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!tag_pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign start_err = start && (state_q != ST_IDLE);

    axpy_tag_pipe #(
        .DEPTH (DEPTH),
        .IDX_W (ADDR_WIDTH)
    ) u_tag_pipe (
        .clk_i     (clk),
        .flush_i   (reset),
        .vld_i     (rd_en),
        .idx_i     (cnt_q),
        .last_i    (cnt_q == LAST_IDX),
        .vld_o     (tag_vld),
        .idx_o     (tag_idx),
        .last_o    (tag_last),
        .pending_o (tag_pending)
    );

    assign rd_addr_a   = a_q + cnt_q;
    assign rd_addr_b   = b_q + cnt_q;
    assign dp_constant = const_q;
    assign dp_op       = op_q;
    assign wr_en       = tag_vld;
    assign wr_addr     = dst_q + tag_idx;
    assign wr_mask     = tag_vld ? (tag_last ? LAST_MASK : FULL_MASK) : '0;

endmodule
